// File: rtl/fact_seq_ctrl.sv
// fact_seq_ctrl: computes N! by issuing one multiply per factor to a shared Booth multiplier.
// Define FACT_TIMEOUT_EN to add a watchdog on mul_done that ends the run with err=1.
module fact_seq_ctrl #(
    parameter int MAX_N       = 20,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic        i_clear,
    input  logic [4:0]  i_n,
    output logic [63:0] o_result,
    output logic        o_done,
    output logic        o_busy,
    output logic        o_ovf,
    output logic        o_err,
    output logic        o_mul_start,
    output logic        o_mul_clear,
    output logic [63:0] o_mul_mtplicand,
    output logic [5:0]  o_mul_mtplier,
    input  logic        i_mul_done,
    input  logic [63:0] i_mul_result
);
    typedef enum logic [2:0] {IDLE, MSTART, MWAIT, MCLR, DRAIN, DRCLR, DONE} state_t;
    state_t      r_state, w_next;
    logic [63:0] r_acc, r_result;
    logic [4:0]  r_k;
    logic        r_ovf, r_err;
    logic        w_timeout;
    logic        w_trivial, w_big;
    assign w_trivial = i_n <= 5'd1;
    assign w_big     = i_n > 5'(MAX_N);
`ifdef FACT_TIMEOUT_EN
    logic [7:0] r_wait;
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            r_wait <= '0;
        else
            r_wait <= (r_state == w_next && (r_state == MWAIT || r_state == DRAIN)) ? r_wait + 8'd1 : '0;
    end
    assign w_timeout = (r_state == MWAIT || r_state == DRAIN) && r_wait == 8'(TIMEOUT_CYC - 1);
`else
    assign w_timeout = 1'b0;
`endif
    // Clear has priority over every other exit so an abort always drains the multiplier.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_start) w_next = (w_trivial || w_big) ? DONE : MSTART;
            MSTART:  w_next = i_clear ? DRAIN : MWAIT;
            MWAIT:   w_next = i_clear ? (i_mul_done ? DRCLR : DRAIN) :
                              i_mul_done ? MCLR : w_timeout ? DONE : MWAIT;
            MCLR:    w_next = i_clear ? IDLE : (r_k == 5'd2) ? DONE : MSTART;
            DRAIN:   w_next = i_mul_done ? DRCLR : w_timeout ? IDLE : DRAIN;
            DRCLR:   w_next = IDLE;
            DONE:    if (i_clear) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= IDLE;
            r_acc    <= '0;
            r_k      <= '0;
            r_result <= '0;
            r_ovf    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: if (i_start) begin
                    r_result <= w_trivial ? 64'd1 : 64'd0;
                    r_ovf    <= !w_trivial && w_big;
                    r_err    <= 1'b0;
                    if (!w_trivial && !w_big) begin
                        r_acc <= 64'd1;
                        r_k   <= i_n;
                    end
                end
                MWAIT: begin
                    if (i_mul_done) r_acc <= i_mul_result;
                    if (w_next == DONE) begin
                        r_err    <= 1'b1;
                        r_result <= '0;
                    end
                end
                MCLR: begin
                    r_k <= r_k - 5'd1;
                    if (w_next == DONE) r_result <= r_acc;
                end
                DRAIN: if (w_next == IDLE) r_err <= 1'b1;
                DONE: if (i_clear) begin
                    r_result <= '0;
                    r_ovf    <= 1'b0;
                    r_err    <= 1'b0;
                end
                default: ;
            endcase
        end
    end
    assign o_result        = r_result;
    assign o_done          = r_state == DONE;
    assign o_busy          = r_state != IDLE && r_state != DONE;
    assign o_ovf           = r_ovf;
    assign o_err           = r_err;
    assign o_mul_start     = r_state == MSTART;
    assign o_mul_clear     = r_state == MCLR || r_state == DRCLR;
    assign o_mul_mtplicand = r_acc;
    assign o_mul_mtplier   = {1'b0, r_k};
endmodule

// File: tb/tb_fact_seq_ctrl.sv
// tb_fact_seq_ctrl: scoreboard bench for fact_seq_ctrl with a behavioural 5-cycle multiplier.
module tb_fact_seq_ctrl;
    logic        clk = 1'b0, reset = 1'b1, start = 1'b0, clear = 1'b0;
    logic [4:0]  n = '0;
    logic [63:0] result, mtplicand, mres, prod;
    logic [5:0]  mtplier;
    logic        done, busy, ovf, err, mstart, mclear, mdone;
    int          cnt;
    bit          stub = 1'b0;
    typedef struct {logic [63:0] r; logic o; logic e;} exp_t;
    exp_t        exp_q[$];
    exp_t        x;
    logic [5:0]  mtp_q[$];
    int          n_chk = 0, n_fail = 0, n_ms = 0, n_mc = 0;
    logic        prev_done = 1'b0;

    fact_seq_ctrl dut (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_clear(clear), .i_n(n),
        .o_result(result), .o_done(done), .o_busy(busy), .o_ovf(ovf), .o_err(err),
        .o_mul_start(mstart), .o_mul_clear(mclear), .o_mul_mtplicand(mtplicand),
        .o_mul_mtplier(mtplier), .i_mul_done(mdone), .i_mul_result(mres)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= 0; mdone <= 1'b0; mres <= '0; prod <= '0;
        end else begin
            mdone <= 1'b0;
            if (mstart) begin
                prod <= 64'(mtplicand * 64'(mtplier));
                cnt  <= 5;
            end else if (cnt > 0) begin
                cnt <= cnt - 1;
                if (cnt == 1 && !stub) begin
                    mdone <= 1'b1;
                    mres  <= prod;
                end
            end
            if (mclear) mres <= '0;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mstart) begin
            n_ms++;
            if (mtp_q.size() > 0) check("mtplier", 64'(mtplier), 64'(mtp_q.pop_front()));
            else check("mstart_unexp", 64'(mstart), 0);
        end
        if (mclear) n_mc++;
        if (done && !prev_done) begin
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                check("result", result, x.r);
                check("ovf", 64'(ovf), 64'(x.o));
                check("err", 64'(err), 64'(x.e));
            end else check("done_unexp", 64'(done), 0);
        end
        prev_done = done;
    end

    task automatic wait_done(output int lat);
        lat = 1;
        while (!done && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        if (!done) check("done_wait", 64'(done), 1);
    endtask

    task automatic run(input int nv, input logic [63:0] r, input logic o, input logic e, output int lat);
        exp_q.push_back('{r, o, e});
        if (nv >= 2 && nv <= 20) begin
            if (e) mtp_q.push_back(6'(nv));
            else for (int k = nv; k >= 2; k--) mtp_q.push_back(6'(k));
        end
        start = 1'b1;
        n = 5'(nv);
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clr_done", 64'(done), 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_result"}, result, 0);
        check({tag, "_done"}, 64'(done), 0);
        check({tag, "_busy"}, 64'(busy), 0);
        check({tag, "_ovf"}, 64'(ovf), 0);
        check({tag, "_err"}, 64'(err), 0);
        check({tag, "_mstart"}, 64'(mstart), 0);
        check({tag, "_mclear"}, 64'(mclear), 0);
        check({tag, "_mtplicand"}, mtplicand, 0);
        check({tag, "_mtplier"}, 64'(mtplier), 0);
    endtask

    initial begin
        int lat, b, s, t;
        repeat (2) @(negedge clk);
        check_zero("rst");
        reset = 1'b0;
        @(negedge clk);
        b = n_ms; run(5, 64'h78, 1'b0, 1'b0, lat); check("n5_nmul", 64'(n_ms - b), 4);
        b = n_ms; run(0, 64'd1, 1'b0, 1'b0, lat); check("n0_lat", 64'(lat), 1); check("n0_nmul", 64'(n_ms - b), 0);
        b = n_ms; run(1, 64'd1, 1'b0, 1'b0, lat); check("n1_lat", 64'(lat), 1); check("n1_nmul", 64'(n_ms - b), 0);
        run(20, 64'h21C3677C82B40000, 1'b0, 1'b0, lat);
        b = n_ms; run(21, 64'd0, 1'b1, 1'b0, lat); check("n21_lat", 64'(lat), 1); check("n21_nmul", 64'(n_ms - b), 0);
        // abort during the second multiply: must drain, never report done
        b = n_mc;
        mtp_q.push_back(6'd6); mtp_q.push_back(6'd5);
        start = 1'b1; n = 5'd6;
        @(negedge clk);
        start = 1'b0;
        s = 0; t = 0;
        while (s < 2 && t < 40) begin
            if (mstart) s++;
            if (s < 2) begin @(negedge clk); t++; end
        end
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("abort_busy", 64'(busy), 1);
        t = 0;
        while (!mclear && t < 20) begin @(negedge clk); t++; end
        check("abort_drclr", 64'(mclear), 1);
        @(negedge clk);
        check("abort_idle_busy", 64'(busy), 0);
        check("abort_idle_done", 64'(done), 0);
        check("abort_nclr", 64'(n_mc - b), 2);
        run(3, 64'd6, 1'b0, 1'b0, lat);
        // start held through DONE is ignored
        exp_q.push_back('{64'd24, 1'b0, 1'b0});
        for (int k = 4; k >= 2; k--) mtp_q.push_back(6'(k));
        start = 1'b1; n = 5'd4;
        @(negedge clk);
        wait_done(lat);
        repeat (3) begin
            @(negedge clk);
            check("held_done", 64'(done), 1);
            check("held_busy", 64'(busy), 0);
        end
        start = 1'b0; clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("held_clr_done", 64'(done), 0);
`ifdef FACT_TIMEOUT_EN
        stub = 1'b1;
        b = n_ms; run(4, 64'd0, 1'b0, 1'b1, lat);
        check("to_lat", 64'(lat), 18); check("to_nmul", 64'(n_ms - b), 1);
        stub = 1'b0;
`endif
        // asynchronous reset in MWAIT
        mtp_q.push_back(6'd5);
        start = 1'b1; n = 5'd5;
        @(negedge clk);
        start = 1'b0;
        t = 0;
        while (!mstart && t < 10) begin @(negedge clk); t++; end
        @(negedge clk);
        check("mwait_busy", 64'(busy), 1);
        #2 reset = 1'b1;
        #1 check_zero("arst");
        mtp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run(2, 64'd2, 1'b0, 1'b0, lat);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
